// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package mult_pkg;

    localparam int W_DEF = 4;

    // 2'b11 is not listed; the FSM treats it exactly like IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUMA = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/multiplicador_secuencial_sumador.sv
// W-bit ripple-carry adder built from full-adder cells (two half adders plus an OR).
// At W=4 this is the SUMADOR_CPA cell chain used by the multiplier datapath.
module multiplicador_secuencial_sumador #(
    parameter int W = 4
) (
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        logic s1;
        logic c1;
        logic c2;

        assign s1     = a[i] ^ b[i];
        assign c1     = a[i] & b[i];
        assign s[i]   = s1 ^ c[i];
        assign c2     = s1 & c[i];
        assign c[i+1] = c1 | c2;
    end

    assign cout = c[W];

endmodule

// File: rtl/multiplicador_secuencial.sv
// Unsigned shift-and-add multiplier: one add/shift iteration per clock over W cycles,
// registered 2W-bit product and a one-cycle done pulse.
module multiplicador_secuencial
    import mult_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P
);

    localparam int CW = $clog2(W) + 1;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  m;
    logic [W-1:0]  acc;
    logic [W-1:0]  q;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  q_next;
    logic [W-1:0]  sum;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          idle;
    logic          accept;
    logic          last_iter;

    multiplicador_secuencial_sumador #(.W(W)) u_sumador (
        .cin  (1'b0),
        .a    (acc),
        .b    (m),
        .s    (sum),
        .cout (carry)
    );

    assign idle      = (state != SUMA) && (state != FIN);
    assign accept    = idle && start;
    assign last_iter = (state == SUMA) && (cnt == CW'(W - 1));

    // The carry-out is shifted into the top of ACC, so no product bit is ever lost.
    always_comb begin
        if (q[0]) begin
            {acc_next, q_next} = {carry, sum, q[W-1:1]};
        end else begin
            {acc_next, q_next} = {1'b0, acc, q[W-1:1]};
        end
    end

    // NOTE: state_next gets its hold value first so no branch can leave it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            SUMA:    if (last_iter) state_next = FIN;
            FIN:     state_next = IDLE;
            default: if (start) state_next = SUMA;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SUMA) || (state_next == FIN);
            done  <= (state_next == FIN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            cnt <= '0;
            P   <= '0;
        end else if (accept) begin
            m   <= A;
            q   <= B;
            acc <= '0;
            cnt <= '0;
        end else if (state == SUMA) begin
            acc <= acc_next;
            q   <= q_next;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
                P <= {acc_next, q_next};
            end
        end
    end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for multiplicador_secuencial: expected products are queued at the
// accepting edge and compared when done is observed.
module tb_multiplicador_secuencial;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];

    multiplicador_secuencial #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy),
        .done  (done),
        .P     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int a, input int b);
        sb.push_back((2*W)'(a * b));
    endtask

    task automatic pop_and_check(input string tag);
        logic [2*W-1:0] exp;
        exp = '0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_p"}, 32'(p), 32'(exp));
        end
    endtask

    // Drives one start pulse through the accepting edge E0.
    task automatic start_op(input string tag, input int a, input int b);
        a_in  = W'(a);
        b_in  = W'(b);
        start = 1'b1;
        push_expected(a, b);
        tick();
        start = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        check({tag, "_done_e0"}, 32'(done), 32'd0);
    endtask

    // Called just after E0; waits a bounded number of edges for done.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        pop_and_check(tag);
        tick();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Asynchronous reset with no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        check("rst_p", 32'(p), 32'h00);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        start_op("max", 15, 15);
        wait_done("max");

        start_op("zero", 0, 9);
        wait_done("zero");

        start_op("typ", 13, 11);
        wait_done("typ");

        start_op("one", 1, 15);
        wait_done("one");

        // Start pulses during SUMA and FIN must be ignored.
        start_op("busy_start", 3, 5);
        tick();
        a_in  = 4'd7;
        b_in  = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_e2_busy", 32'(busy), 32'd1);
        check("busy_start_e2_done", 32'(done), 32'd0);
        tick();
        tick();
        check("busy_start_fin_done", 32'(done), 32'd1);
        pop_and_check("busy_start");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_e5_done", 32'(done), 32'd0);
        check("busy_start_e5_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("busy_start_no_second_done", 32'(done), 32'd0);
        check("busy_start_no_second_busy", 32'(busy), 32'd0);
        check("busy_start_p_held", 32'(p), 32'h0F);

        // start held high: second acceptance at E6 with the then-current operands.
        start_op("b2b_first", 2, 6);
        start = 1'b1;
        a_in  = 4'd9;
        b_in  = 4'd9;
        wait_done("b2b_first");
        push_expected(9, 9);
        tick();
        start = 1'b0;
        check("b2b_second_busy_e6", 32'(busy), 32'd1);
        wait_done("b2b_second");

        // Reset in the middle of an operation: no done pulse, product cleared.
        a_in  = 4'd15;
        b_in  = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_p", 32'(p), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_idle_busy", 32'(busy), 32'd0);

        start_op("after_abort", 4, 4);
        wait_done("after_abort");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
